// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer ahead of the Sobel pipeline: pixel gating, flush rows,
// frame-boundary config double-buffering and stream status pulses.
module sobel_frame_ctrl #(
    parameter int         H_ACT       = 640,
    parameter int         V_ACT       = 480,
    parameter int         FLUSH_ROWS  = 1,
    parameter int         SOBEL_LAT   = 5,
    parameter logic [7:0] THR_DEFAULT = 8'd27
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  frame_start,
    input  logic                                  pix_vld,
    input  logic [7:0]                            pix_y,
    input  logic                                  cfg_wr,
    input  logic [7:0]                            cfg_thr,
    input  logic                                  cfg_bypass,
    output logic                                  isp_wr_en,
    output logic [7:0]                            isp_y,
    output logic [$clog2(H_ACT)-1:0]              isp_col,
    output logic [$clog2(V_ACT+FLUSH_ROWS)-1:0]   isp_row,
    output logic [7:0]                            thr_active,
    output logic                                  bypass_active,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  err_short,
    output logic                                  err_drop
);

    localparam int CW = $clog2(H_ACT);
    localparam int RW = $clog2(V_ACT + FLUSH_ROWS);
    localparam int DW = $clog2(SOBEL_LAT + 2);

    localparam logic [CW-1:0] COL_LAST   = CW'(H_ACT - 1);
    localparam logic [RW-1:0] ROW_ALAST  = RW'(V_ACT - 1);
    localparam logic [RW-1:0] ROW_FLAST  = RW'(V_ACT + FLUSH_ROWS - 1);
    localparam logic [RW-1:0] ROW_FLUSH0 = RW'(V_ACT);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(SOBEL_LAT);

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DRAIN} state_t;

    state_t        state, state_n, eff;
    logic [CW-1:0] col, col_n, bc;
    logic [RW-1:0] row, row_n, br;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [7:0]    thr_pend;
    logic          byp_pend;

    logic          wr_n, done_n, short_n, drop_n;
    logic [7:0]    y_n;
    logic [CW-1:0] ocol_n;
    logic [RW-1:0] orow_n;

    always_comb begin
        state_n = state;
        eff     = state;
        bc      = col;
        br      = row;
        dcnt_n  = '0;
        wr_n    = 1'b0;
        y_n     = '0;
        ocol_n  = '0;
        orow_n  = '0;
        done_n  = 1'b0;
        short_n = 1'b0;
        drop_n  = 1'b0;

        // A frame_start restarts the frame before this cycle's pixel is seen
        if (frame_start) begin
            short_n = (state != IDLE);
            state_n = ACTIVE;
            eff     = ACTIVE;
            bc      = '0;
            br      = '0;
        end
        col_n = bc;
        row_n = br;

        unique case (eff)
            IDLE: begin
                drop_n = pix_vld;
            end
            ACTIVE: begin
                if (pix_vld) begin
                    wr_n   = 1'b1;
                    y_n    = pix_y;
                    ocol_n = bc;
                    orow_n = br;
                    if (bc == COL_LAST) begin
                        col_n = '0;
                        if (br == ROW_ALAST) begin
                            if (FLUSH_ROWS > 0) begin
                                state_n = FLUSH;
                                row_n   = ROW_FLUSH0;
                            end else begin
                                state_n = DRAIN;
                                row_n   = '0;
                            end
                        end else begin
                            row_n = br + 1'b1;
                        end
                    end else begin
                        col_n = bc + 1'b1;
                    end
                end
            end
            FLUSH: begin
                drop_n = pix_vld;
                wr_n   = 1'b1;
                ocol_n = bc;
                orow_n = br;
                if (bc == COL_LAST) begin
                    col_n = '0;
                    if (br == ROW_FLAST) begin
                        state_n = DRAIN;
                        row_n   = '0;
                    end else begin
                        row_n = br + 1'b1;
                    end
                end else begin
                    col_n = bc + 1'b1;
                end
            end
            DRAIN: begin
                drop_n = pix_vld;
                if (dcnt == DCNT_LAST) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            dcnt  <= dcnt_n;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            isp_wr_en  <= 1'b0;
            isp_y      <= '0;
            isp_col    <= '0;
            isp_row    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            isp_wr_en  <= wr_n;
            isp_y      <= y_n;
            isp_col    <= ocol_n;
            isp_row    <= orow_n;
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
            err_short  <= short_n;
            err_drop   <= drop_n;
        end
    end

    // A write coincident with frame_start takes effect in the new frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            thr_pend      <= THR_DEFAULT;
            byp_pend      <= 1'b0;
            thr_active    <= THR_DEFAULT;
            bypass_active <= 1'b0;
        end else begin
            if (cfg_wr) begin
                thr_pend <= cfg_thr;
                byp_pend <= cfg_bypass;
            end
            if (frame_start) begin
                thr_active    <= cfg_wr ? cfg_thr : thr_pend;
                bypass_active <= cfg_wr ? cfg_bypass : byp_pend;
            end
        end
    end

endmodule

// File: doc/sobel_frame_ctrl.md
# sobel_frame_ctrl

Frame-level sequencer that sits between the camera Y-pixel stream and the Sobel edge pipeline.
- Gates and counts incoming pixels per frame and drives the pipeline's write-enable/pixel inputs.
- Appends zero-valued flush rows after the last active row so the 3x3 window pushes the final image row out.
- Double-buffers the edge threshold and bypass configuration so they change only on frame boundaries.
- Reports frame completion and stream errors to the system controller.

## Interface
Parameters:
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- FLUSH_ROWS, 1, zero rows appended after the last active line.
- SOBEL_LAT, 5, pipeline latency in cycles from isp_wr_en to the pipeline's output enable.
- THR_DEFAULT, 8'd27, reset value of the threshold.

Ports:
- sys_clk, in, 1, clock.
- sys_rst_n, in, 1, reset; asynchronous, active-low.
- frame_start, in, 1, single-cycle pulse marking the start of a frame (from vsync edge).
- pix_vld, in, 1, pixel qualifier.
- pix_y, in, 8, luma pixel.
- cfg_wr, in, 1, configuration write strobe.
- cfg_thr, in, 8, threshold to stage.
- cfg_bypass, in, 1, bypass flag to stage.
- isp_wr_en, out, 1, write enable to the Sobel pipeline.
- isp_y, out, 8, pixel to the Sobel pipeline.
- isp_col, out, $clog2(H_ACT), column of the current isp beat.
- isp_row, out, $clog2(V_ACT+FLUSH_ROWS), row of the current isp beat.
- thr_active, out, 8, threshold in force for the current frame.
- bypass_active, out, 1, bypass in force for the current frame.
- busy, out, 1, high when state is not IDLE.
- frame_done, out, 1, one-cycle completion pulse.
- err_short, out, 1, one-cycle pulse: frame aborted before completion.
- err_drop, out, 1, one-cycle pulse: pixel discarded.

## Operation
- Reset: all outputs 0 except thr_active=THR_DEFAULT. Pending config = THR_DEFAULT / 0. State IDLE.
- Config staging:
  - A cfg_wr pulse loads cfg_thr/cfg_bypass into the pending registers in any state.
  - Pending is copied to active on every sampled frame_start.
  - If cfg_wr and frame_start occur in the same cycle, the new cfg values go to both pending and active.
- IDLE: pix_vld is ignored and pulses err_drop. frame_start loads config, clears col/row, and moves to ACTIVE.
- ACTIVE:
  - Each pix_vld beat is forwarded: isp_wr_en=1, isp_y=pix_y, with isp_col/isp_row set to the current count.
  - col increments per beat and wraps H_ACT-1 -> 0, which increments row.
  - Cycles without pix_vld leave the counters unchanged and hold isp_wr_en=0.
  - When the beat at (V_ACT-1, H_ACT-1) is accepted, move to FLUSH.
- FLUSH:
  - Issue FLUSH_ROWS*H_ACT beats on consecutive cycles: isp_wr_en=1, isp_y=0, row continuing from V_ACT.
  - pix_vld in this state is dropped and pulses err_drop.
  - After the last beat, move to DRAIN.
- DRAIN: count SOBEL_LAT cycles, then pulse frame_done and return to IDLE. pix_vld is dropped with err_drop.
- Abort: frame_start in ACTIVE, FLUSH or DRAIN does the following:
  - pulses err_short;
  - loads config and clears counters;
  - enters ACTIVE;
  - does not emit frame_done for the aborted frame.
- Simultaneous frame_start and pix_vld: frame_start is processed first, and that pixel is forwarded as (0,0) of the new frame.
- Counter width rule: counters never exceed H_ACT-1 / V_ACT+FLUSH_ROWS-1. No wrap occurs beyond a frame.

## Timing
- All outputs are registered.
- isp_wr_en/isp_y/isp_col/isp_row lag pix_vld/pix_y by 1 cycle.
- thr_active/bypass_active update 1 cycle after the sampled frame_start, before the first forwarded pixel of that frame appears on isp_wr_en.
- The first FLUSH beat appears on isp_wr_en the cycle after the last active beat, giving a contiguous run.
- frame_done goes high exactly SOBEL_LAT+1 cycles after the last cycle isp_wr_en=1.
- busy goes high 1 cycle after frame_start and goes low in the same cycle frame_done is high.
- err_short and err_drop are 1 cycle wide and 1 cycle after the causing input.
- Asserting reset mid-frame returns the block to IDLE with reset values immediately (asynchronous). Pending config is lost.

## Test plan
Bench parameters: H_ACT=8, V_ACT=4, FLUSH_ROWS=1, SOBEL_LAT=5.
1. Reset, no stimulus -> all outputs 0, thr_active=27, busy=0.
2. frame_start, then 32 contiguous pix_vld with pix_y=row*8+col:
   - isp_wr_en high for 40 consecutive cycles: 32 passthrough beats, then 8 beats with isp_y=0 and isp_row=4.
   - frame_done exactly 6 cycles after the last beat, err pulses none.
3. Same frame with pix_vld toggling 1/0 every cycle -> 32 forwarded beats with correct col/row (no skips), then a contiguous 8-beat flush and one frame_done.
4. cfg_wr thr=50 after pixel 10 of frame 1:
   - thr_active stays 27 through frame 1.
   - thr_active becomes 50 one cycle after the next frame_start.
   - A coincident cfg_wr=80 with frame_start makes it 80.
5. frame_start after 10 pixels -> err_short pulse; the next pixel has isp_col=0, isp_row=0; only one frame_done, after the completed second frame.
6. pix_vld for 3 cycles in IDLE and 2 cycles during FLUSH -> 5 err_drop pulses, with no extra isp_wr_en beats.
